// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and state encoding for the fetch stage.
// Holds the bubble values, reset/clear levels and the if_fetch FSM states.
package if_fetch_pkg;

  localparam logic [31:0] NOP_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  localparam logic ChipRst    = 1'b1;
  localparam logic StageClear = 1'b1;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_DONE  = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_icache.sv
// if_icache: direct-mapped instruction cache, one 32-bit word per line.
// Ports: clk_in, rst_in (async, clears valid bits), rd_pc -> hit/rd_ins
// (combinational lookup), wr_en/wr_pc/wr_ins (synchronous line fill).
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int unsigned LINES = 256
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] rd_pc,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_ins,
  output logic        hit,
  output logic [31:0] rd_ins
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;

  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES];
  logic [LINES-1:0] valid_q;

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;

  assign rd_idx = rd_pc[2 +: IW];
  assign wr_idx = wr_pc[2 +: IW];

  assign hit = valid_q[rd_idx] &&
               (tag_q[rd_idx] == rd_pc[31 -: TW]);
  assign rd_ins = data_q[rd_idx];

  // Word-aligned PCs: the byte offset carries no information.
  logic unused_lsb;
  assign unused_lsb = ^{rd_pc[1:0], wr_pc[1:0]};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_pc[31 -: TW];
      data_q[wr_idx] <= wr_ins;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage; owns the PC and assembles each
// instruction from four byte reads on the shared memory port.
// Inputs: clk_in, rst_in (async, high), rdy_in (freeze), stall,
// jump_en/jump_pc (EX redirect), mem_grant, mem_din.
// Outputs: mem_req/mem_addr (byte request), if_pc/if_ins (NOP bubble
// outside DONE), if_busy (fetch in progress).
// Optional macro ICACHE_EN adds the direct-mapped cache if_icache.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ICACHE_LINES = 256
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_grant,
  input  logic [7:0]  mem_din,
  output logic [31:0] if_pc,
  output logic [31:0] if_ins,
  output logic        if_busy
);

  if ((ICACHE_LINES == 0) ||
      ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0))
  begin : g_lines_chk
    $error("ICACHE_LINES must be a power of two");
  end

  if_state_t   state, state_n;
  logic [31:0] pc, pc_n;
  logic [2:0]  req_cnt, req_cnt_n;
  logic [2:0]  rcv_cnt, rcv_cnt_n;
  logic        pend, pend_n;
  logic [31:0] ins, ins_n;
  logic        mem_req_n;
  logic [31:0] mem_addr_n;
  logic        grant;
  logic        redirect;
  logic        hit;
  logic [31:0] hit_ins;
  logic        show;

  assign grant    = mem_req && mem_grant;
  assign redirect = (jump_en == StageClear);

`ifdef ICACHE_EN
  logic wr_en;

  // Fill on the final byte capture, unless a redirect aborts it.
  assign wr_en = rdy_in && !redirect &&
                 (state == IF_FETCH) && pend &&
                 (rcv_cnt == 3'd3);

  if_icache #(
    .LINES (ICACHE_LINES)
  ) u_icache (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rd_pc  (pc),
    .wr_en  (wr_en),
    .wr_pc  (pc),
    .wr_ins ({mem_din, ins[23:0]}),
    .hit    (hit),
    .rd_ins (hit_ins)
  );
`else
  assign hit     = 1'b0;
  assign hit_ins = NOP_INS;
`endif

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    req_cnt_n = req_cnt;
    rcv_cnt_n = rcv_cnt;
    pend_n    = 1'b0;
    ins_n     = ins;
    unique case (state)
      IF_IDLE: begin
        req_cnt_n = '0;
        rcv_cnt_n = '0;
        if (hit) begin
          state_n = IF_DONE;
          ins_n   = hit_ins;
        end else begin
          state_n = IF_FETCH;
        end
      end
      IF_FETCH: begin
        if (grant) begin
          req_cnt_n = req_cnt + 3'd1;
          pend_n    = 1'b1;
        end
        // pend marks the cycle after a grant: data is on mem_din.
        if (pend) begin
          ins_n[{rcv_cnt[1:0], 3'b000} +: 8] = mem_din;
          rcv_cnt_n = rcv_cnt + 3'd1;
          if (rcv_cnt == 3'd3) state_n = IF_DONE;
        end
      end
      IF_DONE: begin
        if (!stall) begin
          pc_n    = pc + 32'd4;
          state_n = IF_IDLE;
        end
      end
      default: state_n = IF_IDLE;
    endcase
    // Redirect beats everything, and drops any byte in flight.
    if (redirect) begin
      state_n = IF_IDLE;
      pc_n    = jump_pc;
      pend_n  = 1'b0;
    end
    mem_req_n  = (state_n == IF_FETCH) &&
                 (req_cnt_n < 3'd4);
    mem_addr_n = mem_req_n ?
                 pc_n + {29'd0, req_cnt_n} : mem_addr;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IF_IDLE;
      pc       <= RESET_PC;
      req_cnt  <= '0;
      rcv_cnt  <= '0;
      pend     <= 1'b0;
      ins      <= NOP_INS;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (rdy_in) begin
      state    <= state_n;
      pc       <= pc_n;
      req_cnt  <= req_cnt_n;
      rcv_cnt  <= rcv_cnt_n;
      pend     <= pend_n;
      ins      <= ins_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
    end
  end

  // A redirect bubbles the output in the same cycle.
  assign show    = (state == IF_DONE) &&
                   !(rdy_in && redirect);
  assign if_pc   = show ? pc  : NOP_PC;
  assign if_ins  = show ? ins : NOP_INS;
  assign if_busy = (state == IF_FETCH);

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed timing checks plus a randomized run against
// a PC/byte-stream reference model of the fetch stage.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam int unsigned LINES = 256;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        stall;
  logic        jump_en;
  logic [31:0] jump_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_grant;
  logic [7:0]  mem_din = 8'h00;
  logic [31:0] if_pc;
  logic [31:0] if_ins;
  logic        if_busy;

  logic [7:0] mem [8192];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  if_fetch #(
    .RESET_PC     (32'h0),
    .ICACHE_LINES (LINES)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .stall     (stall),
    .jump_en   (jump_en),
    .jump_pc   (jump_pc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_grant (mem_grant),
    .mem_din   (mem_din),
    .if_pc     (if_pc),
    .if_ins    (if_ins),
    .if_busy   (if_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    int b;
    b = int'(a[12:0]);
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  // Memory controller: data the cycle after an accepted grant,
  // junk otherwise; holds its value while the chip is not ready.
  always @(posedge clk_in) begin : mem_model
    logic        g;
    logic        r;
    logic [31:0] a;
    g = rdy_in && !rst_in && mem_req && mem_grant;
    r = rdy_in;
    a = mem_addr;
    #1;
    if (g) mem_din = mem[a[12:0]];
    else if (r) mem_din = 8'($urandom);
  end

  task automatic do_reset();
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    stall     = 1'b0;
    jump_en   = 1'b0;
    jump_pc   = 32'h0;
    mem_grant = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  logic [31:0] m_pc;
  int          m_k;
  int          n_pres;
  logic        pres;
  logic [31:0] w;

  initial begin
    for (int i = 0; i < 8192; i += 4) begin
      w = $urandom;
      if (w == NOP_INS) w = w ^ 32'h100;
      {mem[i+3], mem[i+2], mem[i+1], mem[i]} = w;
    end
    {mem[3], mem[2], mem[1], mem[0]} = 32'h0000_0013;

    do_reset();

    for (int c = 0; c <= 43; c++) begin
      mem_grant = !(c >= 9 && c <= 11);
      stall     = (c >= 16 && c <= 20) || c == 32 || c == 33;
      jump_en   = (c == 25) || (c == 33);
      jump_pc   = (c == 25) ? 32'h100 : 32'h200;
      rdy_in    = !(c >= 37 && c <= 39);
      @(negedge clk_in);
      case (c)
        0: begin
          chk("rst_req", mem_req, 0);
          chk("rst_addr", mem_addr, 0);
          chk("rst_busy", if_busy, 0);
          chk("rst_pc", if_pc, NOP_PC);
          chk("rst_ins", if_ins, NOP_INS);
        end
        1, 2, 3, 4: begin
          chk("t1_req", mem_req, 1);
          chk("t1_addr", mem_addr, 32'(c - 1));
          chk("t1_busy", if_busy, 1);
        end
        5: begin
          chk("t1_req_end", mem_req, 0);
          chk("t1_busy5", if_busy, 1);
        end
        6: begin
          chk("t1_done_busy", if_busy, 0);
          chk("t1_pc", if_pc, 32'h0);
          chk("t1_ins", if_ins, 32'h13);
        end
        8: begin
          chk("t1_next_req", mem_req, 1);
          chk("t1_next_addr", mem_addr, 32'h4);
        end
        9, 10, 11, 12: begin
          chk("t2_hold_req", mem_req, 1);
          chk("t2_hold_addr", mem_addr, 32'h5);
        end
        13: chk("t2_addr6", mem_addr, 32'h6);
        16, 17, 18, 19, 20, 21: begin
          chk("t3_pc", if_pc, 32'h4);
          chk("t3_ins", if_ins, word(32'h4));
          chk("t3_noreq", mem_req, 0);
          chk("t3_busy", if_busy, 0);
        end
        23: begin
          chk("t3_adv_req", mem_req, 1);
          chk("t3_adv_addr", mem_addr, 32'h8);
        end
        25: begin
          chk("t4_jmp_pc", if_pc, NOP_PC);
          chk("t4_jmp_ins", if_ins, NOP_INS);
        end
        26: begin
          chk("t4_idle_req", mem_req, 0);
          chk("t4_idle_busy", if_busy, 0);
          chk("t4_idle_ins", if_ins, NOP_INS);
        end
        27: begin
          chk("t4_new_req", mem_req, 1);
          chk("t4_new_addr", mem_addr, 32'h100);
        end
        31: chk("t4_bubble", if_ins, NOP_INS);
        32: begin
          chk("t4_pc", if_pc, 32'h100);
          chk("t4_ins", if_ins, word(32'h100));
        end
        33: begin
          chk("t5_jmp_pc", if_pc, NOP_PC);
          chk("t5_jmp_ins", if_ins, NOP_INS);
        end
        35: begin
          chk("t5_req", mem_req, 1);
          chk("t5_addr", mem_addr, 32'h200);
        end
        36: chk("t5_addr1", mem_addr, 32'h201);
        37, 38, 39, 40: begin
          chk("t5_frz_req", mem_req, 1);
          chk("t5_frz_addr", mem_addr, 32'h202);
          chk("t5_frz_busy", if_busy, 1);
        end
        41: chk("t5_addr3", mem_addr, 32'h203);
        42: chk("t5_req_end", mem_req, 0);
        43: begin
          chk("t5_pc", if_pc, 32'h200);
          chk("t5_ins", if_ins, word(32'h200));
        end
        default: ;
      endcase
      @(posedge clk_in);
      #1;
    end

    m_pc   = 32'h0;
    m_k    = 0;
    n_pres = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 0) begin
        rdy_in  = 1'b1;
        stall   = 1'b0;
        jump_en = 1'b1;
        jump_pc = 32'h400;
      end else begin
        rdy_in  = ($urandom_range(0, 9) != 0);
        stall   = ($urandom_range(0, 2) == 0);
        jump_en = ($urandom_range(0, 49) == 0);
        jump_pc = 32'h400 + ($urandom_range(0, 767) << 2);
      end
      mem_grant = ($urandom_range(0, 3) != 0);
      @(negedge clk_in);
      pres = (if_ins != NOP_INS);
      if (pres) begin
        n_pres++;
        chk("rnd_pc", if_pc, m_pc);
        chk("rnd_ins", if_ins, word(m_pc));
      end else begin
        chk("rnd_bubble_pc", if_pc, NOP_PC);
      end
      if (rdy_in) begin
        if (mem_req && mem_grant) begin
          chk("rnd_k", 32'(m_k < 4), 1);
          chk("rnd_addr", mem_addr, m_pc + 32'(m_k));
          m_k++;
        end
        if (jump_en) begin
          m_pc = jump_pc;
          m_k  = 0;
        end else if (pres && !stall) begin
          m_pc = m_pc + 32'd4;
          m_k  = 0;
        end
      end
      @(posedge clk_in);
      #1;
    end
    chk("rnd_progress", 32'(n_pres > 100), 1);

`ifdef ICACHE_EN
    do_reset();
    for (int c = 0; c <= 36; c++) begin
      rdy_in    = 1'b1;
      stall     = 1'b0;
      mem_grant = 1'b1;
      jump_en   = (c == 20) || (c == 27) || (c == 34);
      jump_pc   = (c == 27) ? 32'(LINES * 4) : 32'h0;
      @(negedge clk_in);
      case (c)
        13: begin
          chk("c_miss_pc", if_pc, 32'h4);
          chk("c_miss_ins", if_ins, word(32'h4));
        end
        21, 22, 23, 25, 27: chk("c_hit_noreq", mem_req, 0);
        24: begin
          chk("c_hit_noreq4", mem_req, 0);
          chk("c_hit_pc", if_pc, 32'h4);
          chk("c_hit_ins", if_ins, word(32'h4));
        end
        26: begin
          chk("c_hit_noreq8", mem_req, 0);
          chk("c_hit_pc8", if_pc, 32'h8);
          chk("c_hit_ins8", if_ins, word(32'h8));
        end
        29: begin
          chk("c_alias_req", mem_req, 1);
          chk("c_alias_addr", mem_addr, 32'(LINES * 4));
        end
        36: begin
          chk("c_evict_req", mem_req, 1);
          chk("c_evict_addr", mem_addr, 32'h0);
        end
        default: ;
      endcase
      @(posedge clk_in);
      #1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
